// File: rtl/synth_voice_pkg.sv
// Shared types for the synth voice allocation slice.
// Event encodings, FSM states and the empty note-table marker.
package synth_voice_pkg;

    typedef enum logic [1:0] {
        EV_NOTE_ON  = 2'b00,
        EV_NOTE_OFF = 2'b01,
        EV_ALL_OFF  = 2'b10,
        EV_RSVD     = 2'b11
    } ev_type_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SCAN   = 2'b01,
        COMMIT = 2'b10
    } alloc_state_t;

    localparam logic [7:0] NOTE_EMPTY = 8'hff;

endpackage

// File: rtl/voice_allocator_pick.sv
// Combinational voice selection: note match, lowest free voice,
// oldest released voice, oldest voice overall (steal).
module voice_pick #(
    parameter int VOICES  = 8,
    parameter int V_WIDTH = 3
) (
    input  logic [VOICES-1:0]         key_on,
    input  logic [VOICES*8-1:0]       note_tab,
    input  logic [VOICES*V_WIDTH-1:0] rank_tab,
    input  logic [VOICES-1:0]         vf_q,
    input  logic [6:0]                note,
    output logic                      match_hit,
    output logic [V_WIDTH-1:0]        match_idx,
    output logic [V_WIDTH-1:0]        target_idx,
    output logic                      steal_flag
);

    logic               free_hit;
    logic [V_WIDTH-1:0] free_idx;
    logic               rel_hit;
    logic [V_WIDTH-1:0] rel_idx;
    logic [V_WIDTH-1:0] rel_rank;
    logic [V_WIDTH-1:0] old_idx;
    logic [V_WIDTH-1:0] old_rank;

    // Scan all voices; downward loops leave the lowest index, rank compares keep the oldest
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (key_on[i] && note_tab[i*8 +: 8] == {1'b0, note}) begin
                match_hit = 1'b1;
                match_idx = V_WIDTH'(i);
            end
            if (!key_on[i] && vf_q[i]) begin
                free_hit = 1'b1;
                free_idx = V_WIDTH'(i);
            end
        end
        rel_hit  = 1'b0;
        rel_idx  = '0;
        rel_rank = '0;
        old_idx  = '0;
        old_rank = rank_tab[0 +: V_WIDTH];
        for (int i = 0; i < VOICES; i++) begin
            if (!key_on[i] &&
                (!rel_hit || rank_tab[i*V_WIDTH +: V_WIDTH] > rel_rank)) begin
                rel_hit  = 1'b1;
                rel_idx  = V_WIDTH'(i);
                rel_rank = rank_tab[i*V_WIDTH +: V_WIDTH];
            end
            if (rank_tab[i*V_WIDTH +: V_WIDTH] > old_rank) begin
                old_idx  = V_WIDTH'(i);
                old_rank = rank_tab[i*V_WIDTH +: V_WIDTH];
            end
        end
        steal_flag = !match_hit && !free_hit && !rel_hit;
        if (match_hit)     target_idx = match_idx;
        else if (free_hit) target_idx = free_idx;
        else if (rel_hit)  target_idx = rel_idx;
        else               target_idx = old_idx;
    end

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator: accepts MIDI note events, picks a voice
// (free-first, oldest-steal), keeps the gate vector, strobes updates.
module voice_allocator
    import synth_voice_pkg::*;
#(
    parameter int VOICES  = 8,
    parameter int V_WIDTH = 3
) (
    input  logic               reg_clk,
    input  logic               reset_reg_N,
    input  logic               ev_valid,
    output logic               ev_ready,
    input  logic [1:0]         ev_type,
    input  logic [6:0]         ev_note,
    input  logic [6:0]         ev_vel,
    input  logic [VOICES-1:0]  voice_free,
    output logic [VOICES-1:0]  key_on,
    output logic               upd_valid,
    output logic [V_WIDTH-1:0] upd_voice,
    output logic [7:0]         upd_note,
    output logic [7:0]         upd_vel,
    output logic               upd_gate,
    output logic               steal,
    output logic [V_WIDTH:0]   active_keys
);

    alloc_state_t               state;
    ev_type_t                   type_q;
    logic [6:0]                 note_q;
    logic [6:0]                 vel_q;
    logic [VOICES-1:0]          vf_q;
    logic [VOICES*8-1:0]        note_tab;
    logic [VOICES*V_WIDTH-1:0]  rank_tab;
    logic [VOICES*V_WIDTH-1:0]  rank_nxt;
    logic                       match_hit;
    logic [V_WIDTH-1:0]         match_idx;
    logic [V_WIDTH-1:0]         target_idx;
    logic                       steal_flag;
    logic                       is_on;
    logic                       is_off;
    logic [V_WIDTH:0]           key_cnt;

    assign ev_ready = (state == IDLE);
    assign is_on    = (type_q == EV_NOTE_ON) && (vel_q != 7'd0);
    assign is_off   = (type_q == EV_NOTE_OFF) ||
                      ((type_q == EV_NOTE_ON) && (vel_q == 7'd0));

    voice_pick #(
        .VOICES  (VOICES),
        .V_WIDTH (V_WIDTH)
    ) u_pick (
        .key_on     (key_on),
        .note_tab   (note_tab),
        .rank_tab   (rank_tab),
        .vf_q       (vf_q),
        .note       (note_q),
        .match_hit  (match_hit),
        .match_idx  (match_idx),
        .target_idx (target_idx),
        .steal_flag (steal_flag)
    );

    // Age every voice newer than the target; the target becomes newest
    always_comb begin
        rank_nxt = rank_tab;
        for (int i = 0; i < VOICES; i++) begin
            if (rank_tab[i*V_WIDTH +: V_WIDTH] <
                rank_tab[target_idx*V_WIDTH +: V_WIDTH])
                rank_nxt[i*V_WIDTH +: V_WIDTH] =
                    rank_tab[i*V_WIDTH +: V_WIDTH] + 1'b1;
        end
        rank_nxt[target_idx*V_WIDTH +: V_WIDTH] = '0;
    end

    // Population count of the gate vector
    always_comb begin
        key_cnt = '0;
        for (int i = 0; i < VOICES; i++)
            key_cnt = key_cnt + {{V_WIDTH{1'b0}}, key_on[i]};
    end

    // Event FSM; the table and update outputs are written entering COMMIT
    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state       <= IDLE;
            type_q      <= EV_RSVD;
            note_q      <= '0;
            vel_q       <= '0;
            vf_q        <= '0;
            key_on      <= '0;
            upd_valid   <= 1'b0;
            upd_voice   <= '0;
            upd_note    <= '0;
            upd_vel     <= '0;
            upd_gate    <= 1'b0;
            steal       <= 1'b0;
            active_keys <= '0;
            note_tab    <= {VOICES{NOTE_EMPTY}};
            for (int i = 0; i < VOICES; i++)
                rank_tab[i*V_WIDTH +: V_WIDTH] <= V_WIDTH'(i);
        end else begin
            upd_valid   <= 1'b0;
            steal       <= 1'b0;
            active_keys <= key_cnt;
            case (state)
                IDLE: begin
                    if (ev_valid) begin
                        type_q <= ev_type_t'(ev_type);
                        note_q <= ev_note;
                        vel_q  <= ev_vel;
                        vf_q   <= voice_free;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    state <= COMMIT;
                    if (is_on) begin
                        key_on[target_idx]             <= 1'b1;
                        note_tab[target_idx*8 +: 8]    <= {1'b0, note_q};
                        rank_tab                       <= rank_nxt;
                        upd_valid <= 1'b1;
                        upd_voice <= target_idx;
                        upd_note  <= {1'b0, note_q};
                        upd_vel   <= {1'b0, vel_q};
                        upd_gate  <= 1'b1;
                        steal     <= steal_flag;
                    end else if (is_off && match_hit) begin
                        key_on[match_idx]          <= 1'b0;
                        note_tab[match_idx*8 +: 8] <= NOTE_EMPTY;
                        upd_valid <= 1'b1;
                        upd_voice <= match_idx;
                        upd_note  <= {1'b0, note_q};
                        upd_vel   <= {1'b0, vel_q};
                        upd_gate  <= 1'b0;
                    end else if (type_q == EV_ALL_OFF) begin
                        key_on   <= '0;
                        note_tab <= {VOICES{NOTE_EMPTY}};
                    end
                end
                COMMIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed-vector bench for voice_allocator.
// Expected values are hand-derived from the allocation rules.
module tb_voice_allocator;

    logic       reg_clk = 1'b0;
    logic       reset_reg_N = 1'b0;
    logic       ev_valid = 1'b0;
    logic       ev_ready;
    logic [1:0] ev_type = 2'd0;
    logic [6:0] ev_note = 7'd0;
    logic [6:0] ev_vel = 7'd0;
    logic [7:0] voice_free = 8'hff;
    logic [7:0] key_on;
    logic       upd_valid;
    logic [2:0] upd_voice;
    logic [7:0] upd_note;
    logic [7:0] upd_vel;
    logic       upd_gate;
    logic       steal;
    logic [3:0] active_keys;

    int vectors = 0;
    int miscompares = 0;

    logic       got_valid;
    logic [2:0] got_voice;
    logic [7:0] got_note;
    logic [7:0] got_vel;
    logic       got_gate;
    logic       got_steal;
    logic [7:0] got_key;
    logic       seen;

    voice_allocator dut (
        .reg_clk     (reg_clk),
        .reset_reg_N (reset_reg_N),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_type     (ev_type),
        .ev_note     (ev_note),
        .ev_vel      (ev_vel),
        .voice_free  (voice_free),
        .key_on      (key_on),
        .upd_valid   (upd_valid),
        .upd_voice   (upd_voice),
        .upd_note    (upd_note),
        .upd_vel     (upd_vel),
        .upd_gate    (upd_gate),
        .steal       (steal),
        .active_keys (active_keys)
    );

    always #5 reg_clk = ~reg_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        reset_reg_N = 1'b0;
        ev_valid    = 1'b0;
        @(posedge reg_clk);
        #1;
        reset_reg_N = 1'b1;
        @(posedge reg_clk);
        #1;
    endtask

    // Called #1 after a clock edge with the DUT in IDLE; returns likewise
    task automatic do_ev(input logic [1:0] t, input logic [6:0] n,
                         input logic [6:0] v);
        check("ready", {31'd0, ev_ready}, 32'd1);
        ev_type  = t;
        ev_note  = n;
        ev_vel   = v;
        ev_valid = 1'b1;
        @(posedge reg_clk);
        #1;
        ev_valid = 1'b0;
        check("scan_quiet", {31'd0, upd_valid}, 32'd0);
        @(posedge reg_clk);
        #1;
        got_valid = upd_valid;
        got_voice = upd_voice;
        got_note  = upd_note;
        got_vel   = upd_vel;
        got_gate  = upd_gate;
        got_steal = steal;
        got_key   = key_on;
        @(posedge reg_clk);
        #1;
    endtask

    initial begin
        #2;
        check("rst_ready", {31'd0, ev_ready}, 32'd1);
        check("rst_key", {24'd0, key_on}, 32'h00);
        check("rst_act", {28'd0, active_keys}, 32'd0);
        check("rst_upd", {31'd0, upd_valid}, 32'd0);
        check("rst_steal", {31'd0, steal}, 32'd0);
        reset_dut();

        // First note-on lands on voice 0
        voice_free = 8'hff;
        do_ev(2'b00, 7'd60, 7'd100);
        check("t1_valid", {31'd0, got_valid}, 32'd1);
        check("t1_voice", {29'd0, got_voice}, 32'd0);
        check("t1_note", {24'd0, got_note}, 32'd60);
        check("t1_vel", {24'd0, got_vel}, 32'd100);
        check("t1_gate", {31'd0, got_gate}, 32'd1);
        check("t1_key", {24'd0, key_on}, 32'h01);
        check("t1_act", {28'd0, active_keys}, 32'd1);

        // Fill all voices then steal the oldest
        reset_dut();
        voice_free = 8'hff;
        for (int i = 0; i < 8; i++) begin
            do_ev(2'b00, 7'(60 + i), 7'd100);
            check("t2_fill", {29'd0, got_voice}, i);
        end
        voice_free = 8'h00;
        do_ev(2'b00, 7'd70, 7'd90);
        check("t2_valid", {31'd0, got_valid}, 32'd1);
        check("t2_steal", {31'd0, got_steal}, 32'd1);
        check("t2_voice", {29'd0, got_voice}, 32'd0);
        check("t2_note", {24'd0, got_note}, 32'd70);
        check("t2_key", {24'd0, key_on}, 32'hff);
        check("t2_act", {28'd0, active_keys}, 32'd8);
        check("t2_pulse", {31'd0, steal}, 32'd0);

        // Note-off of a held note, then a repeat that matches nothing
        reset_dut();
        voice_free = 8'hff;
        do_ev(2'b00, 7'd60, 7'd100);
        do_ev(2'b00, 7'd61, 7'd100);
        do_ev(2'b00, 7'd62, 7'd100);
        do_ev(2'b01, 7'd61, 7'd40);
        check("t3_valid", {31'd0, got_valid}, 32'd1);
        check("t3_voice", {29'd0, got_voice}, 32'd1);
        check("t3_gate", {31'd0, got_gate}, 32'd0);
        check("t3_vel", {24'd0, got_vel}, 32'd40);
        check("t3_note", {24'd0, got_note}, 32'd61);
        check("t3_key", {24'd0, key_on}, 32'h05);
        check("t3_act", {28'd0, active_keys}, 32'd2);
        do_ev(2'b01, 7'd61, 7'd40);
        check("t3_nomatch", {31'd0, got_valid}, 32'd0);
        check("t3_key2", {24'd0, key_on}, 32'h05);

        // Velocity-zero note-on releases the held note
        do_ev(2'b00, 7'd60, 7'd0);
        check("t4_valid", {31'd0, got_valid}, 32'd1);
        check("t4_voice", {29'd0, got_voice}, 32'd0);
        check("t4_gate", {31'd0, got_gate}, 32'd0);
        check("t4_vel", {24'd0, got_vel}, 32'd0);
        check("t4_key", {24'd0, key_on}, 32'h04);

        // Release tail: oldest released voice is reused, no steal
        reset_dut();
        voice_free = 8'hff;
        for (int i = 0; i < 8; i++)
            do_ev(2'b00, 7'(60 + i), 7'd100);
        voice_free = 8'h00;
        do_ev(2'b01, 7'd60, 7'd10);
        do_ev(2'b01, 7'd61, 7'd10);
        check("t5_keyrel", {24'd0, key_on}, 32'hfc);
        do_ev(2'b00, 7'd72, 7'd80);
        check("t5_voice", {29'd0, got_voice}, 32'd0);
        check("t5_steal", {31'd0, got_steal}, 32'd0);
        check("t5_key", {24'd0, key_on}, 32'hfd);

        // Retrigger of a held note reuses its voice
        do_ev(2'b00, 7'd63, 7'd50);
        check("t5_retrig", {29'd0, got_voice}, 32'd3);
        check("t5_rsteal", {31'd0, got_steal}, 32'd0);
        check("t5_rvel", {24'd0, got_vel}, 32'd50);

        // Reserved type is consumed with no effect
        do_ev(2'b11, 7'd20, 7'd20);
        check("rsvd_upd", {31'd0, got_valid}, 32'd0);
        check("rsvd_key", {24'd0, key_on}, 32'hfd);

        // All-notes-off clears gates without an update strobe
        do_ev(2'b10, 7'd0, 7'd0);
        check("t6_upd", {31'd0, got_valid}, 32'd0);
        check("t6_keyc", {24'd0, got_key}, 32'h00);
        check("t6_key", {24'd0, key_on}, 32'h00);
        check("t6_act", {28'd0, active_keys}, 32'd0);

        // Async reset in SCAN aborts the event
        voice_free = 8'hff;
        do_ev(2'b00, 7'd64, 7'd100);
        check("t7_pre", {24'd0, key_on}, 32'h01);
        ev_type  = 2'b00;
        ev_note  = 7'd65;
        ev_vel   = 7'd100;
        ev_valid = 1'b1;
        @(posedge reg_clk);
        #1;
        ev_valid = 1'b0;
        check("t7_scan", {31'd0, ev_ready}, 32'd0);
        reset_reg_N = 1'b0;
        #1;
        check("t7_ready", {31'd0, ev_ready}, 32'd1);
        check("t7_key", {24'd0, key_on}, 32'h00);
        check("t7_act", {28'd0, active_keys}, 32'd0);
        @(posedge reg_clk);
        #1;
        reset_reg_N = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge reg_clk);
            #1;
            if (upd_valid) seen = 1'b1;
        end
        check("t7_noupd", {31'd0, seen}, 32'd0);
        check("t7_key2", {24'd0, key_on}, 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Schedules the synth's VOICES voice slots between incoming MIDI note events.
- Accepts decoded note-on, note-off and all-notes-off events from the MIDI front end over a valid/ready handshake.
- Picks a voice using a free-first, oldest-steal policy, maintains the per-voice gate vector, and issues one update strobe per committed allocation or release to synth_engine.

Parameters:
VOICES, 8, number of voice slots
V_WIDTH, 3, log2(VOICES)

Ports:
reg_clk  in  1  system register clock
reset_reg_N  in  1  reset, asynchronous, active-low
ev_valid  in  1  event present
ev_ready  out  1  allocator can accept an event
ev_type  in  2  00 note-on, 01 note-off, 10 all-notes-off, 11 reserved
ev_note  in  7  MIDI note number
ev_vel  in  7  MIDI velocity (on or release)
voice_free  in  VOICES  per-voice envelope finished (from synth_engine)
key_on  out  VOICES  per-voice gate
upd_valid  out  1  one-cycle update strobe
upd_voice  out  V_WIDTH  voice index being updated
upd_note  out  8  note value written to the voice
upd_vel  out  8  velocity written to the voice
upd_gate  out  1  1 = note start, 0 = release
steal  out  1  one-cycle pulse: a held voice was stolen
active_keys  out  V_WIDTH+1  population count of key_on, registered

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE.
  - key_on, upd_*, steal and active_keys go to 0; ev_ready goes to 1.
  - Note table entries go to 8'hff (empty).
  - rank[i] = i.
- State: note[VOICES] (8 bit), rank[VOICES] (V_WIDTH bit).
  - rank is a permutation of 0..VOICES-1; 0 = newest.
- FSM IDLE -> SCAN -> COMMIT -> IDLE.
  - ev_ready = 1 only in IDLE.
  - The handshake completes on ev_valid & ev_ready; the event is latched in that cycle.
  - Throughput is one event per 3 cycles.
- SCAN: registers voice_free, then computes the match, free and oldest selections from registered state.
- COMMIT: writes state; upd_valid/steal asserted for exactly this cycle.
  - Latency: handshake at cycle N, upd_valid at N+2.
- Note-on with ev_vel != 0; the target voice is the first rule that applies:
  - 1. A held voice with note == {1'b0,ev_note}: retrigger that voice.
  - 2. The lowest-index voice with key_on=0 and voice_free=1.
  - 3. Among key_on=0 voices (release tail), the one with the highest rank.
  - 4. Among all voices, the highest rank; steal=1.
  - On commit:
    - key_on[v] = 1 and note[v] = ev_note.
    - upd_gate = 1, upd_note = {0,ev_note}, upd_vel = {0,ev_vel}.
    - Rank update: voices with rank < rank[v] increment; rank[v] = 0.
- Note-on with ev_vel == 0: handled exactly as note-off with release velocity 0.
- Note-off:
  - Match rule: held voice with matching note, lowest index on duplicates.
  - On match:
    - key_on[v] = 0 and note[v] = 8'hff.
    - upd_gate = 0, upd_note = {0,ev_note}, upd_vel = {0,ev_vel}.
    - rank is unchanged.
  - No match: no upd_valid, state unchanged, return to IDLE.
- All-notes-off:
  - In COMMIT: all key_on = 0, all note = 8'hff, ranks preserved.
  - upd_valid is not asserted.
- Reserved type: consumed, no effect.
- active_keys is updated one cycle after the key_on change.
- Register upd_voice/upd_note/upd_vel/upd_gate; they hold their last value outside COMMIT.
- voice_free changing during SCAN/COMMIT: only the SCAN-registered copy is used.
- ev_valid held high across commit: the next event is accepted in the following IDLE cycle.

Decomposition:
- Package synth_voice_pkg holds:
  - ev_type_t enum (EV_NOTE_ON, EV_NOTE_OFF, EV_ALL_OFF, EV_RSVD)
  - NOTE_EMPTY = 8'hff
  - alloc_state_t enum (IDLE, SCAN, COMMIT)
- Sub-module voice_pick, purely combinational:
  - Inputs: key_on, note table, rank, registered voice_free, note.
  - Outputs: match_hit/match_idx, target_idx, steal_flag.
  - The allocator FSM instantiates it once.

Test Plan:
- Reset, then note-on 60/vel 100 with all voice_free=1:
  - upd_valid 2 cycles after handshake, upd_voice=0, upd_note=60, upd_gate=1.
  - key_on=8'h01, active_keys=1.
- 8 note-ons 60..67 followed by note-on 70, all voice_free=0 after allocation:
  - steal=1, upd_voice=0 (oldest, note 60), key_on stays 8'hff, active_keys=8.
- Notes 60,61,62 on voices 0..2; note-off 61 vel 40:
  - upd_voice=1, upd_gate=0, upd_vel=40, key_on=8'h05.
  - A following note-off 61 gives no upd_valid.
- Note-on 60 vel 0 while 60 is held on voice 0: treated as release, upd_gate=0, key_on[0]=0.
- Voices 0,1 released (voice_free=0), voices 2..7 held, note-on 72:
  - Picks the released voice with the higher rank (voice 0 if released earlier); steal=0.
- Held notes, then all-notes-off:
  - key_on=0 and active_keys=0 the cycle after COMMIT; no upd_valid.
- Async reset asserted in SCAN: ev_ready=1, key_on=0, no upd_valid after release.
